// File: rtl/ext_mem_bw_if.sv
// Bus bundle between the chip-side master and the external memory model.
// The parameters must match those of the ext_mem_bw instance it connects to.
interface ext_mem_bw_if #(
    parameter int WIDTH     = 32,
    parameter int AW        = 20,
    parameter int CNT_WIDTH = 48
);
    logic                   read_en;
    logic [AW-1:0]          read_addr;
    logic [WIDTH-1:0]       qout;
    logic                   qout_valid;
    logic                   write_en;
    logic [AW-1:0]          write_addr;
    logic [WIDTH-1:0]       din;
    logic                   conflict;
    logic                   cnt_clear;
    logic [CNT_WIDTH-1:0]   rd_words;
    logic [CNT_WIDTH-1:0]   wr_words;
    logic [CNT_WIDTH-1:0]   conflict_cnt;
    logic [CNT_WIDTH+7:0]   total_bits;

    modport master (
        output read_en, read_addr, write_en, write_addr, din, cnt_clear,
        input  qout, qout_valid, conflict, rd_words, wr_words, conflict_cnt, total_bits
    );

    modport slave (
        input  read_en, read_addr, write_en, write_addr, din, cnt_clear,
        output qout, qout_valid, conflict, rd_words, wr_words, conflict_cnt, total_bits
    );
endinterface

// File: rtl/ext_mem_bw.sv
// Behavioural off-chip memory with configurable read latency, optional
// single-port arbitration and saturating bandwidth counters.
module ext_mem_bw #(
    parameter int WIDTH        = 32,
    parameter int HEIGHT       = 1 << 20,
    parameter int READ_LATENCY = 1,
    parameter int SINGLE_PORT  = 0,
    parameter int CNT_WIDTH    = 48
) (
    input  logic         clk,
    input  logic         arst_n_in,
    ext_mem_bw_if.slave  bus
);
    localparam int AW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam bit SP = (SINGLE_PORT != 0);

    logic [WIDTH-1:0]     mem [HEIGHT];
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic                 rd_drop;
    logic                 rd_accept;
    logic [WIDTH-1:0]     rd_data;

    logic [READ_LATENCY-1:0] pipe_vld;
    logic [WIDTH-1:0]        pipe_dat [READ_LATENCY];

    logic                 conflict_q;
    logic [CNT_WIDTH-1:0] rd_words_q;
    logic [CNT_WIDTH-1:0] wr_words_q;
    logic [CNT_WIDTH-1:0] conflict_cnt_q;
    logic [CNT_WIDTH+7:0] word_sum;

    // The extra top bit keeps the range check meaningful when HEIGHT is a power of two.
    assign wr_in_range = ({1'b0, bus.write_addr} < (AW+1)'(HEIGHT));
    assign rd_in_range = ({1'b0, bus.read_addr}  < (AW+1)'(HEIGHT));
    assign rd_drop     = SP && bus.read_en && bus.write_en;
    assign rd_accept   = bus.read_en && !rd_drop;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (bus.write_en && wr_in_range) begin
            mem[bus.write_addr] <= bus.din;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            rd_data = mem[bus.read_addr];
        end
    end

    // Data stages only advance behind a valid bit, so the last stage holds the last returned word.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_accept;
            if (rd_accept) begin
                pipe_dat[0] <= rd_data;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            conflict_q     <= 1'b0;
            rd_words_q     <= '0;
            wr_words_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            conflict_q <= rd_drop;
            if (bus.cnt_clear) begin
                rd_words_q     <= '0;
                wr_words_q     <= '0;
                conflict_cnt_q <= '0;
            end else begin
                if (rd_accept)    rd_words_q     <= sat_inc(rd_words_q);
                if (bus.write_en) wr_words_q     <= sat_inc(wr_words_q);
                if (rd_drop)      conflict_cnt_q <= sat_inc(conflict_cnt_q);
            end
        end
    end

    assign word_sum = (CNT_WIDTH+8)'(rd_words_q) + (CNT_WIDTH+8)'(wr_words_q);

    assign bus.qout         = pipe_dat[READ_LATENCY-1];
    assign bus.qout_valid   = pipe_vld[READ_LATENCY-1];
    assign bus.conflict     = conflict_q;
    assign bus.rd_words     = rd_words_q;
    assign bus.wr_words     = wr_words_q;
    assign bus.conflict_cnt = conflict_cnt_q;
    assign bus.total_bits   = word_sum * (CNT_WIDTH+8)'(WIDTH);
endmodule

// File: tb/tb_ext_mem_bw.sv
// Directed self-checking bench: three memory configurations share one clock and reset.
module tb_ext_mem_bw;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   seen;

    always #5 clk = ~clk;

    // a: dual-port, latency 1, 4-bit counters; b: dual-port, latency 3; c: single-port, latency 4
    ext_mem_bw_if #(.WIDTH(32), .AW(5), .CNT_WIDTH(4))  bus_a ();
    ext_mem_bw_if #(.WIDTH(32), .AW(5), .CNT_WIDTH(48)) bus_b ();
    ext_mem_bw_if #(.WIDTH(32), .AW(5), .CNT_WIDTH(8))  bus_c ();

    ext_mem_bw #(.WIDTH(32), .HEIGHT(20), .READ_LATENCY(1), .SINGLE_PORT(0), .CNT_WIDTH(4))
        u_a (.clk(clk), .arst_n_in(arst_n), .bus(bus_a));
    ext_mem_bw #(.WIDTH(32), .HEIGHT(20), .READ_LATENCY(3), .SINGLE_PORT(0), .CNT_WIDTH(48))
        u_b (.clk(clk), .arst_n_in(arst_n), .bus(bus_b));
    ext_mem_bw #(.WIDTH(32), .HEIGHT(20), .READ_LATENCY(4), .SINGLE_PORT(1), .CNT_WIDTH(8))
        u_c (.clk(clk), .arst_n_in(arst_n), .bus(bus_c));

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic idle_all();
        bus_a.read_en = 1'b0; bus_a.write_en = 1'b0; bus_a.cnt_clear = 1'b0;
        bus_a.read_addr = '0; bus_a.write_addr = '0; bus_a.din = '0;
        bus_b.read_en = 1'b0; bus_b.write_en = 1'b0; bus_b.cnt_clear = 1'b0;
        bus_b.read_addr = '0; bus_b.write_addr = '0; bus_b.din = '0;
        bus_c.read_en = 1'b0; bus_c.write_en = 1'b0; bus_c.cnt_clear = 1'b0;
        bus_c.read_addr = '0; bus_c.write_addr = '0; bus_c.din = '0;
    endtask

    initial begin
        idle_all();
        repeat (3) @(negedge clk);
        checkOutput("rst_a_qout",       64'(bus_a.qout),         64'h0);
        checkOutput("rst_a_valid",      64'(bus_a.qout_valid),   64'h0);
        checkOutput("rst_c_conflict",   64'(bus_c.conflict),     64'h0);
        checkOutput("rst_a_rd_words",   64'(bus_a.rd_words),     64'h0);
        checkOutput("rst_c_conf_cnt",   64'(bus_c.conflict_cnt), 64'h0);
        checkOutput("rst_b_total_bits", 64'(bus_b.total_bits),   64'h0);
        arst_n = 1'b1;
        @(negedge clk);

        // Write then read back on the next cycle
        bus_a.write_en = 1'b1; bus_a.write_addr = 5'd5; bus_a.din = 32'hDEADBEEF;
        @(negedge clk);
        bus_a.write_en = 1'b0; bus_a.read_en = 1'b1; bus_a.read_addr = 5'd5;
        @(negedge clk);
        checkOutput("a_rd_valid",    64'(bus_a.qout_valid), 64'h1);
        checkOutput("a_rd_data",     64'(bus_a.qout),       64'hDEADBEEF);
        checkOutput("a_rd_words",    64'(bus_a.rd_words),   64'h1);
        checkOutput("a_wr_words",    64'(bus_a.wr_words),   64'h1);
        checkOutput("a_total_bits",  64'(bus_a.total_bits), 64'd64);
        bus_a.read_en = 1'b0;
        @(negedge clk);
        checkOutput("a_valid_drop",  64'(bus_a.qout_valid), 64'h0);
        checkOutput("a_qout_hold",   64'(bus_a.qout),       64'hDEADBEEF);

        // Same-address read and write in one cycle returns the old word
        bus_a.write_en = 1'b1; bus_a.write_addr = 5'd7; bus_a.din = 32'd1;
        @(negedge clk);
        bus_a.din = 32'd2; bus_a.read_en = 1'b1; bus_a.read_addr = 5'd7;
        @(negedge clk);
        bus_a.write_en = 1'b0;
        checkOutput("a_read_first",  64'(bus_a.qout),       64'd1);
        @(negedge clk);
        checkOutput("a_read_after",  64'(bus_a.qout),       64'd2);

        // Out-of-range read and write are counted; the read returns zero
        bus_a.read_addr = 5'd25; bus_a.write_en = 1'b1; bus_a.write_addr = 5'd25; bus_a.din = 32'hFFFF;
        @(negedge clk);
        idle_all();
        checkOutput("a_oor_data",    64'(bus_a.qout),       64'h0);
        checkOutput("a_oor_valid",   64'(bus_a.qout_valid), 64'h1);
        checkOutput("a_oor_rd",      64'(bus_a.rd_words),   64'd4);
        checkOutput("a_oor_wr",      64'(bus_a.wr_words),   64'd4);
        checkOutput("a_oor_total",   64'(bus_a.total_bits), 64'd256);

        // 20 more writes saturate the 4-bit write counter
        for (int i = 0; i < 20; i++) begin
            bus_a.write_en = 1'b1; bus_a.write_addr = 5'(i); bus_a.din = 32'(100 + i);
            @(negedge clk);
        end
        idle_all();
        checkOutput("a_sat_wr",      64'(bus_a.wr_words),   64'd15);
        checkOutput("a_sat_total",   64'(bus_a.total_bits), 64'd608);

        // Clear wins over the concurrent write, but the write still lands
        bus_a.cnt_clear = 1'b1; bus_a.write_en = 1'b1; bus_a.write_addr = 5'd11; bus_a.din = 32'h1234;
        @(negedge clk);
        idle_all();
        checkOutput("a_clr_rd",      64'(bus_a.rd_words),   64'h0);
        checkOutput("a_clr_wr",      64'(bus_a.wr_words),   64'h0);
        checkOutput("a_clr_total",   64'(bus_a.total_bits), 64'h0);
        bus_a.read_en = 1'b1; bus_a.read_addr = 5'd11;
        @(negedge clk);
        bus_a.read_en = 1'b0;
        checkOutput("a_clr_data",    64'(bus_a.qout),       64'h1234);
        checkOutput("a_clr_rd_one",  64'(bus_a.rd_words),   64'h1);

        // Latency 3: four back-to-back reads of 10..13
        for (int i = 0; i < 4; i++) begin
            bus_b.write_en = 1'b1; bus_b.write_addr = 5'(i); bus_b.din = 32'(10 + i);
            @(negedge clk);
        end
        idle_all();
        for (int j = 0; j < 9; j++) begin
            if (j > 0) begin
                checkOutput($sformatf("b_valid_%0d", j - 1), 64'(bus_b.qout_valid),
                            64'((j - 1 >= 2) && (j - 1 <= 5)));
                if ((j - 1 >= 2) && (j - 1 <= 5)) begin
                    checkOutput($sformatf("b_data_%0d", j - 1), 64'(bus_b.qout), 64'(10 + j - 3));
                end
            end
            bus_b.read_en = (j < 4); bus_b.read_addr = 5'(j);
            @(negedge clk);
        end
        bus_b.read_en = 1'b0;
        checkOutput("b_rd_words",    64'(bus_b.rd_words),   64'd4);

        // Single-port collision drops the read
        bus_c.read_en = 1'b1; bus_c.read_addr = 5'd9;
        bus_c.write_en = 1'b1; bus_c.write_addr = 5'd9; bus_c.din = 32'h55;
        @(negedge clk);
        idle_all();
        checkOutput("c_conflict",    64'(bus_c.conflict),     64'h1);
        checkOutput("c_conf_cnt",    64'(bus_c.conflict_cnt), 64'h1);
        checkOutput("c_rd_words",    64'(bus_c.rd_words),     64'h0);
        checkOutput("c_wr_words",    64'(bus_c.wr_words),     64'h1);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus_c.qout_valid) seen++;
            if (k == 0) checkOutput("c_conflict_pulse", 64'(bus_c.conflict), 64'h0);
        end
        checkOutput("c_no_valid",    64'(seen), 64'h0);
        bus_c.read_en = 1'b1; bus_c.read_addr = 5'd9;
        @(negedge clk);
        bus_c.read_en = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("c_lat_early",   64'(bus_c.qout_valid), 64'h0);
        @(negedge clk);
        checkOutput("c_lat_valid",   64'(bus_c.qout_valid), 64'h1);
        checkOutput("c_lat_data",    64'(bus_c.qout),       64'h55);

        // Reset while a read is in flight
        bus_c.read_en = 1'b1; bus_c.read_addr = 5'd9;
        @(negedge clk);
        bus_c.read_en = 1'b0;
        @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        checkOutput("c_rst_valid",   64'(bus_c.qout_valid), 64'h0);
        checkOutput("c_rst_rd",      64'(bus_c.rd_words),   64'h0);
        arst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_c.qout_valid) seen++;
        end
        checkOutput("c_rst_no_valid", 64'(seen),              64'h0);
        checkOutput("c_rst_wr",       64'(bus_c.wr_words),    64'h0);
        checkOutput("c_rst_conf_cnt", 64'(bus_c.conflict_cnt), 64'h0);
        bus_a.read_en = 1'b1; bus_a.read_addr = 5'd11;
        bus_c.read_en = 1'b1; bus_c.read_addr = 5'd9;
        @(negedge clk);
        idle_all();
        checkOutput("a_keep_data",   64'(bus_a.qout),       64'h1234);
        repeat (3) @(negedge clk);
        checkOutput("c_keep_valid",  64'(bus_c.qout_valid), 64'h1);
        checkOutput("c_keep_data",   64'(bus_c.qout),       64'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ext_mem_bw.md
# ext_mem_bw

Parametrised behavioural model of the off-chip memory that `top_chip` reads and writes in the system wrapper. It generalises the earlier fixed pseudo-2-port memory with a configurable read latency, a selectable single-port mode and built-in bandwidth counters. Every word that crosses the chip boundary is counted here, so the wrapper reports bandwidth without any bench-side bookkeeping. Storage is simulation-only; it is not reset and is not synthesised.

## Interface
- `WIDTH`, 32: data word width in bits (`EXT_MEM_WIDTH`).
- `HEIGHT`, 1<<20: number of words; need not be a power of two.
- `READ_LATENCY`, 1: cycles from read request to data; legal range 1..4.
- `SINGLE_PORT`, 0: 1 = one access per cycle, 0 = one read plus one write per cycle.
- `CNT_WIDTH`, 48: width of each bandwidth counter.
- `AW` (localparam), `$clog2(HEIGHT)`: address width.

Ports:
- `clk`  in  1  system clock.
- `arst_n_in`  in  1  asynchronous reset, active low.
- `read_en`  in  1  read request, sampled on the rising edge.
- `read_addr`  in  AW  read address.
- `qout`  out  WIDTH  read data.
- `qout_valid`  out  1  `qout` carries the data for the request issued `READ_LATENCY` cycles earlier.
- `write_en`  in  1  write request.
- `write_addr`  in  AW  write address.
- `din`  in  WIDTH  write data.
- `conflict`  out  1  registered one-cycle pulse: a read was dropped because of a single-port collision.
- `cnt_clear`  in  1  synchronous clear of all counters.
- `rd_words`  out  CNT_WIDTH  accepted reads.
- `wr_words`  out  CNT_WIDTH  accepted writes.
- `conflict_cnt`  out  CNT_WIDTH  dropped reads.
- `total_bits`  out  CNT_WIDTH+8  (rd_words+wr_words)*WIDTH, combinational from the counters.

## Operation
- Writes: when `write_en`=1 and `write_addr`<HEIGHT, `din` is stored at the clock edge. Writes to addresses >=HEIGHT are discarded but still counted.
- Reads: when `read_en` is accepted, the array is read at the clock edge. The result enters a shift pipeline of depth `READ_LATENCY`, together with a valid bit. Reads from addresses >=HEIGHT return 0 and are still counted.
- Dual-port (`SINGLE_PORT`=0): a read and a write in the same cycle both proceed. If they target the same address, the read returns the old data (read-first).
- Single-port (`SINGLE_PORT`=1): when `read_en` and `write_en` are both 1, the write proceeds and the read is dropped.
  - A dropped read produces no `qout_valid`.
  - `conflict`=1 in the next cycle and `conflict_cnt` increments.
  - `rd_words` does not count the dropped read.
- `qout` holds its last valid value while `qout_valid`=0.
- Counters increment by 1 per accepted access and saturate at all-ones; they never wrap.
- `cnt_clear` has priority over increments. In a cycle with `cnt_clear`=1, all counters go to 0 and accesses in that same cycle are not counted. The accesses themselves still execute.

## Timing
- Reset values: `qout`=0, `qout_valid`=0, `conflict`=0, all counters 0. The read pipeline valid bits are cleared immediately on reset assertion.
- Reset asserted mid-read: in-flight reads are lost and no `qout_valid` appears after release. Array contents are preserved.
- Read latency: a read accepted at edge N gives `qout_valid`=1 and data in the cycle after edge N+READ_LATENCY-1. With `READ_LATENCY`=1 the data is registered at the same edge that samples the request.
- Throughput: one read per cycle, back-to-back, with no bubbles; this also holds for writes in dual-port mode.
- Write-to-read: a write at edge N is visible to a read sampled at edge N+1 or later.
- The counters, `conflict` and `qout_valid` are all registered. `total_bits` follows the counters combinationally, with no extra latency.

## Test plan
- Reset, write, read (dual, L=1): write 0xDEADBEEF to address 5, then read address 5 on the next cycle. Expect `qout`=0xDEADBEEF with `qout_valid` one cycle after the request, `rd_words`=1, `wr_words`=1, `total_bits`=64.
- Latency sweep (L=3): issue 4 back-to-back reads of addresses 0..3 preloaded with 10..13. Expect `qout_valid` high for exactly 4 consecutive cycles starting 3 cycles after the first request, with data 10, 11, 12, 13.
- Same-address read/write (dual): address 7 holds 1; in one cycle write 2 to 7 and read 7. Expect the read returns 1, and a following read returns 2.
- Single-port collision: `read_en` and `write_en` both asserted, write 0x55 to address 9. Expect no `qout_valid`, `conflict` pulse of 1 cycle, `conflict_cnt`=1, `rd_words`=0, `wr_words`=1, and address 9 = 0x55.
- Clear and saturation (CNT_WIDTH=4):
  - 20 writes: expect `wr_words`=15 (saturated).
  - `cnt_clear` together with one write: expect all counters 0 next cycle, and the write is stored.
- Reset mid-flight (L=4): issue a read, assert `arst_n_in`=0 two cycles later, then release. Expect no `qout_valid`, counters 0, and previously written data still readable.
